// File: rtl/fifo_pattern_checker.sv
// Read-side FIFO soak checker: fall-through pops, verifies a mod-2^DSIZE incrementing sequence; rinc is combinational, status one cycle after each pop.
// Backpressure: pops only while enable and ~rempty and the READ_GAP pacing counter is 0; FIFO_CHECK_CAPTURE_EN adds first-mismatch capture.
module fifo_pattern_checker #(
  parameter int DSIZE         = 8,
  parameter int CNT_W         = 16,
  parameter int READ_GAP      = 0,
  parameter int RESYNC_THRESH = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             rempty,
  input  logic             arempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             locked,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_flag,
  output logic [DSIZE-1:0] last_data,
  output logic [DSIZE-1:0] first_err_exp,
  output logic [DSIZE-1:0] first_err_got
);

  localparam int GAP_W = (READ_GAP > 0) ? $clog2(READ_GAP + 1) : 1;

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  state_t             state_q, state_d;
  logic [DSIZE-1:0]   exp_q, exp_d;
  logic [7:0]         mism_q, mism_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               locked_q, locked_d;
  logic [CNT_W-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               flag_q, flag_d;
  logic [DSIZE-1:0]   last_q, last_d;

  logic               mismatch;
  logic               thresh_hit;
  logic               unused_arempty;

  // almost-empty is reported by the FIFO but deliberately ignored by control
  assign unused_arempty = arempty;

  assign mismatch   = rinc && (state_q == CHECK) && (rdata != exp_q);
  assign thresh_hit = (mism_q + 8'd1) == 8'(RESYNC_THRESH);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      mism_q   <= '0;
      gap_q    <= '0;
      locked_q <= 1'b0;
      word_q   <= '0;
      err_q    <= '0;
      flag_q   <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      mism_q   <= mism_d;
      gap_q    <= gap_d;
      locked_q <= locked_d;
      word_q   <= word_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = enable ? SYNC : IDLE;
    end else if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = locked_q ? CHECK : SYNC;
        SYNC:    if (rinc) state_d = CHECK;
        CHECK:   if (mismatch && thresh_hit) state_d = SYNC;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    rinc       = enable && !rempty && (gap_q == '0) && (state_q != IDLE);
    locked     = locked_q;
    word_count = word_q;
    err_count  = err_q;
    err_flag   = flag_q;
    last_data  = last_q;
  end

  always_comb begin
    exp_d    = exp_q;
    mism_d   = mism_q;
    locked_d = locked_q;
    word_d   = word_q;
    err_d    = err_q;
    flag_d   = flag_q;
    last_d   = last_q;

    if (rinc)
      gap_d = GAP_W'(READ_GAP);
    else if (gap_q != '0)
      gap_d = gap_q - GAP_W'(1);
    else
      gap_d = gap_q;

    // clear wins over a simultaneous pop: the word leaves the FIFO unchecked
    if (clear) begin
      mism_d   = '0;
      locked_d = 1'b0;
      word_d   = '0;
      err_d    = '0;
      flag_d   = 1'b0;
    end else if (rinc) begin
      last_d = rdata;
      if (word_q != '1) word_d = word_q + CNT_W'(1);
      if (state_q == SYNC) begin
        exp_d    = rdata + DSIZE'(1);
        locked_d = 1'b1;
        mism_d   = '0;
      end else if (!mismatch) begin
        exp_d  = exp_q + DSIZE'(1);
        mism_d = '0;
      end else begin
        exp_d  = exp_q + DSIZE'(1);
        flag_d = 1'b1;
        mism_d = mism_q + 8'd1;
        if (err_q != '1) err_d = err_q + CNT_W'(1);
        if (thresh_hit) locked_d = 1'b0;
      end
    end
  end

`ifdef FIFO_CHECK_CAPTURE_EN
  logic [DSIZE-1:0] cap_exp_q, cap_exp_d;
  logic [DSIZE-1:0] cap_got_q, cap_got_d;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cap_exp_q <= '0;
      cap_got_q <= '0;
    end else begin
      cap_exp_q <= cap_exp_d;
      cap_got_q <= cap_got_d;
    end
  end

  always_comb begin
    cap_exp_d = cap_exp_q;
    cap_got_d = cap_got_q;
    if (clear) begin
      cap_exp_d = '0;
      cap_got_d = '0;
    end else if (mismatch && !flag_q) begin
      cap_exp_d = exp_q;
      cap_got_d = rdata;
    end
  end

  assign first_err_exp = cap_exp_q;
  assign first_err_got = cap_got_q;
`else
  assign first_err_exp = '0;
  assign first_err_got = '0;
`endif

endmodule

// File: tb/tb_fifo_pattern_checker.sv
// Directed bench for fifo_pattern_checker: a back-to-back instance and a READ_GAP=2 instance.
module tb_fifo_pattern_checker;

  logic        rclk = 1'b0;
  logic        rrst_n = 1'b0;
  logic        clear = 1'b0;
  logic        arempty = 1'b1;

  logic        enable = 1'b0;
  logic        rempty = 1'b1;
  logic [7:0]  rdata = 8'h00;
  logic        rinc, locked, err_flag;
  logic [15:0] word_count, err_count;
  logic [7:0]  last_data, first_err_exp, first_err_got;

  logic        g_enable = 1'b0;
  logic        g_rempty = 1'b1;
  logic [7:0]  g_rdata = 8'h00;
  logic        g_rinc, g_locked, g_err_flag;
  logic [15:0] g_word_count, g_err_count;
  logic [7:0]  g_last_data, g_first_err_exp, g_first_err_got;

  int n_checks = 0;
  int n_errors = 0;
  int rinc_hits = 0;

  always #5 rclk = ~rclk;

  fifo_pattern_checker #(.DSIZE(8), .CNT_W(16), .READ_GAP(0), .RESYNC_THRESH(4)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .clear(clear),
    .rempty(rempty), .arempty(arempty), .rdata(rdata), .rinc(rinc),
    .locked(locked), .word_count(word_count), .err_count(err_count),
    .err_flag(err_flag), .last_data(last_data),
    .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  fifo_pattern_checker #(.DSIZE(8), .CNT_W(16), .READ_GAP(2), .RESYNC_THRESH(4)) dut_gap (
    .rclk(rclk), .rrst_n(rrst_n), .enable(g_enable), .clear(clear),
    .rempty(g_rempty), .arempty(arempty), .rdata(g_rdata), .rinc(g_rinc),
    .locked(g_locked), .word_count(g_word_count), .err_count(g_err_count),
    .err_flag(g_err_flag), .last_data(g_last_data),
    .first_err_exp(g_first_err_exp), .first_err_got(g_first_err_got)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // present one word for one cycle; it is popped on the following rising edge
  task automatic feed(input logic [7:0] d);
    @(negedge rclk);
    rdata  = d;
    rempty = 1'b0;
    #1;
    if (rinc) rinc_hits++;
    @(posedge rclk);
  endtask

  task automatic settle();
    @(negedge rclk);
    rempty = 1'b1;
    #1;
  endtask

  task automatic pulse_clear();
    @(negedge rclk);
    clear  = 1'b1;
    rempty = 1'b1;
    @(negedge rclk);
    clear = 1'b0;
    #1;
  endtask

  initial begin : stim
    logic       prev;
    logic [8:0] pat;
    logic [7:0] seq_a [5];
    logic [7:0] seq_b [4];
    seq_a = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
    seq_b = '{8'h10, 8'h11, 8'h13, 8'h14};

    // reset held with a live FIFO: nothing may pop
    enable = 1'b1;
    rempty = 1'b0;
    repeat (2) @(posedge rclk);
    @(negedge rclk); #1;
    chk("rst_rinc", rinc, 0);
    chk("rst_locked", locked, 0);
    chk("rst_words", word_count, 0);
    chk("rst_errs", err_count, 0);
    chk("rst_flag", err_flag, 0);
    chk("rst_last", last_data, 0);
    chk("rst_cap_exp", first_err_exp, 0);
    chk("rst_cap_got", first_err_got, 0);
    chk("rst_g_rinc", g_rinc, 0);
    @(negedge rclk);
    rempty = 1'b1;
    rrst_n = 1'b1;
    @(posedge rclk);

    // 1: twenty back-to-back words
    rinc_hits = 0;
    for (int i = 0; i < 20; i++) feed(8'(i));
    chk("t1_rinc_run", rinc_hits, 20);
    settle();
    chk("t1_rinc_empty", rinc, 0);
    chk("t1_words", word_count, 20);
    chk("t1_errs", err_count, 0);
    chk("t1_locked", locked, 1);
    chk("t1_last", last_data, 8'h13);
    chk("t1_flag", err_flag, 0);

    // 2: wrap through 0xFF
    pulse_clear();
    chk("t2_clr_words", word_count, 0);
    chk("t2_clr_locked", locked, 0);
    for (int i = 0; i < 5; i++) feed(seq_a[i]);
    settle();
    chk("t2_errs", err_count, 0);
    chk("t2_words", word_count, 5);
    chk("t2_last", last_data, 8'h01);
    chk("t2_locked", locked, 1);

    // 3: skipped word gives two errors, first capture 0x12/0x13
    pulse_clear();
    for (int i = 0; i < 4; i++) feed(seq_b[i]);
    settle();
    chk("t3_errs", err_count, 2);
    chk("t3_flag", err_flag, 1);
    chk("t3_locked", locked, 1);
`ifdef FIFO_CHECK_CAPTURE_EN
    chk("t3_cap_exp", first_err_exp, 8'h12);
    chk("t3_cap_got", first_err_got, 8'h13);
`else
    chk("t3_cap_exp", first_err_exp, 0);
    chk("t3_cap_got", first_err_got, 0);
`endif

    // 4: four consecutive mismatches drop lock, next word relocks
    pulse_clear();
    feed(8'h00);
    for (int i = 0; i < 3; i++) feed(8'h55);
    settle();
    chk("t4_locked_3", locked, 1);
    chk("t4_errs_3", err_count, 3);
    feed(8'h55);
    settle();
    chk("t4_locked_4", locked, 0);
    chk("t4_errs_4", err_count, 4);
    feed(8'h80);
    settle();
    chk("t4_relock", locked, 1);
    feed(8'h81);
    settle();
    chk("t4_errs_after", err_count, 4);
    chk("t4_words", word_count, 7);

    // enable drop with data waiting: rinc falls at once, counters hold
    @(negedge rclk);
    rdata  = 8'h82;
    rempty = 1'b0;
    enable = 1'b0;
    #1;
    chk("en_drop_rinc", rinc, 0);
    @(negedge rclk); #1;
    chk("en_drop_rinc2", rinc, 0);
    chk("en_drop_words", word_count, 7);
    @(negedge rclk);
    enable = 1'b1;
    #1;
    chk("en_idle_rinc", rinc, 0);
    // still locked, so re-entry is CHECK and a wrong word is an error
    feed(8'h90);
    settle();
    chk("en_back_errs", err_count, 5);
    chk("en_back_words", word_count, 8);

    // 5: READ_GAP=2 instance pops every third cycle
    @(negedge rclk);
    g_enable = 1'b1;
    g_rempty = 1'b0;
    g_rdata  = 8'h00;
    #1;
    chk("g_idle_rinc", g_rinc, 0);
    prev = 1'b0;
    pat  = '0;
    for (int i = 0; i < 9; i++) begin
      @(negedge rclk);
      if (prev) g_rdata = g_rdata + 8'd1;
      #1;
      pat  = {pat[7:0], g_rinc};
      prev = g_rinc;
    end
    chk("g_pattern", pat, 9'b100_100_100);
    @(negedge rclk);
    if (prev) g_rdata = g_rdata + 8'd1;
    g_rempty = 1'b1;
    #1;
    chk("g_empty_rinc", g_rinc, 0);
    chk("g_words_3", g_word_count, 3);
    @(negedge rclk);
    g_rempty = 1'b0;
    #1;
    chk("g_refill_rinc", g_rinc, 1);
    repeat (2) @(negedge rclk);
    g_rdata = 8'h04;
    @(negedge rclk);
    g_enable = 1'b0;
    #1;
    chk("g_en_drop_rinc", g_rinc, 0);
    repeat (2) @(negedge rclk);
    #1;
    chk("g_words_hold", g_word_count, 4);
    chk("g_errs", g_err_count, 0);
    chk("g_flag", g_err_flag, 0);
    chk("g_locked", g_locked, 1);
    chk("g_last", g_last_data, 8'h03);
    chk("g_cap_exp", g_first_err_exp, 0);
    chk("g_cap_got", g_first_err_got, 0);

    // 6: clear with err_count = 3 and a simultaneous pop
    pulse_clear();
    feed(8'h20);
    for (int i = 0; i < 3; i++) feed(8'h00);
    settle();
    chk("t6_errs_pre", err_count, 3);
    chk("t6_locked_pre", locked, 1);
    @(negedge rclk);
    clear  = 1'b1;
    rdata  = 8'h40;
    rempty = 1'b0;
    #1;
    chk("t6_clr_rinc", rinc, 1);
    @(negedge rclk);
    clear  = 1'b0;
    rempty = 1'b1;
    #1;
    chk("t6_clr_words", word_count, 0);
    chk("t6_clr_errs", err_count, 0);
    chk("t6_clr_flag", err_flag, 0);
    chk("t6_clr_locked", locked, 0);
    feed(8'h41);
    settle();
    chk("t6_sync_locked", locked, 1);
    chk("t6_sync_words", word_count, 1);
    feed(8'h99);
    settle();
    chk("t6_err_pre_rst", err_count, 1);

    // asynchronous reset between edges while a pop is pending
    @(negedge rclk);
    rdata  = 8'h42;
    rempty = 1'b0;
    #1;
    chk("rst2_rinc_pre", rinc, 1);
    #2 rrst_n = 1'b0;
    #1;
    chk("rst2_rinc", rinc, 0);
    chk("rst2_locked", locked, 0);
    chk("rst2_words", word_count, 0);
    chk("rst2_errs", err_count, 0);
    chk("rst2_flag", err_flag, 0);
    chk("rst2_last", last_data, 0);
    chk("rst2_cap_exp", first_err_exp, 0);
    chk("rst2_cap_got", first_err_got, 0);
    @(negedge rclk);
    rrst_n = 1'b1;
    rempty = 1'b1;
    repeat (2) @(posedge rclk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
